// File: rtl/mux_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module      : mux_arbiter_2to1
// Description : Two-requester arbiter driving a shared data multiplexer.
//               Contention goes to the requester that was not served last.
//               The owner gives up the path when it signals done, drops its
//               request, or reaches MAX_HOLD cycles of tenure. A tenure cut
//               short by the hold limit raises a one-cycle timeout pulse.
//               The path passes straight to a waiting requester, with no
//               idle cycle in between.
// Ports       : clk            - system clock, rising edge
//               rst_n          - synchronous active-low reset
//               req_a / req_b  - path requests
//               done_a / done_b- release strobes, used only by the owner
//               data_a / data_b- requester data, WIDTH bits
//               grant_a/grant_b- registered ownership flags
//               sel            - registered mux select (0 = A, 1 = B)
//               data_z         - muxed data, zero when nobody owns the path
//               busy           - either grant high
//               timeout        - one-cycle pulse after a forced release
// Revision    : 1.0 - initial release
// ============================================================================
module mux_arbiter_2to1 #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             done_a,
    input  logic             done_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             grant_a,
    output logic             grant_b,
    output logic             sel,
    output logic [WIDTH-1:0] data_z,
    output logic             busy,
    output logic             timeout
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_gnt_a = 2'd1;
    localparam logic [1:0] c_st_gnt_b = 2'd2;

    // The counter starts at 0 on the first cycle of a tenure, so the last
    // permitted cycle of that tenure is the one where it reads MAX_HOLD-1.
    localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);

    logic [1:0] r_state;
    logic [7:0] r_cnt;
    logic       r_last_b;   // 1 = B was served most recently
    logic       r_sel;
    logic       r_timeout;

    logic [1:0] w_state_nxt;
    logic       w_take_a;
    logic       w_take_b;
    logic       w_forced;
    logic       w_expired;

    assign w_expired = (r_cnt == c_hold_last);

    always_comb begin
        w_state_nxt = r_state;
        w_take_a    = 1'b0;
        w_take_b    = 1'b0;
        w_forced    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (req_a && req_b) begin
                    w_take_a = r_last_b;
                    w_take_b = ~r_last_b;
                end else begin
                    w_take_a = req_a;
                    w_take_b = req_b;
                end
            end
            c_st_gnt_a: begin
                if (done_a || !req_a || w_expired) begin
                    // Done or a dropped request makes this a normal release.
                    w_forced = ~done_a & req_a;
                    if (req_b) begin
                        w_take_b = 1'b1;
                    end else begin
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            c_st_gnt_b: begin
                if (done_b || !req_b || w_expired) begin
                    w_forced = ~done_b & req_b;
                    if (req_a) begin
                        w_take_a = 1'b1;
                    end else begin
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
        if (w_take_a) begin
            w_state_nxt = c_st_gnt_a;
        end
        if (w_take_b) begin
            w_state_nxt = c_st_gnt_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_cnt     <= 8'd0;
            r_last_b  <= 1'b1;
            r_sel     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timeout <= w_forced;
            if (w_take_a) begin
                r_cnt    <= 8'd0;
                r_sel    <= 1'b0;
                r_last_b <= 1'b0;
            end else if (w_take_b) begin
                r_cnt    <= 8'd0;
                r_sel    <= 1'b1;
                r_last_b <= 1'b1;
            end else if (w_state_nxt == c_st_idle) begin
                r_cnt <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign grant_a = (r_state == c_st_gnt_a);
    assign grant_b = (r_state == c_st_gnt_b);
    assign busy    = grant_a | grant_b;
    assign sel     = r_sel;
    assign timeout = r_timeout;
    assign data_z  = grant_a ? data_a : (grant_b ? data_b : '0);

endmodule
`default_nettype wire

// File: tb/tb_mux_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_arbiter_2to1
// Description : Self-checking bench for mux_arbiter_2to1. Directed scenarios
//               followed by random traffic, all compared against an
//               ownership/tenure reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_arbiter_2to1;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 16;

    logic             clk;
    logic             rst_n;
    logic             req_a, req_b, done_a, done_b;
    logic [WIDTH-1:0] data_a, data_b;
    logic             grant_a, grant_b, sel, busy, timeout;
    logic [WIDTH-1:0] data_z;

    int n_checks;
    int n_errors;

    // Reference model: who owns the path, how many cycles it has owned it
    // (1 on the first cycle), who won last, and the expected sel/timeout.
    int m_owner;   // 0 none, 1 A, 2 B
    int m_tenure;
    int m_last;    // 1 A, 2 B
    bit m_sel;
    bit m_to;
    bit r_prev_to;

    mux_arbiter_2to1 #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_a   (req_a),
        .req_b   (req_b),
        .done_a  (done_a),
        .done_b  (done_b),
        .data_a  (data_a),
        .data_b  (data_b),
        .grant_a (grant_a),
        .grant_b (grant_b),
        .sel     (sel),
        .data_z  (data_z),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_grant(input int who);
        m_owner  = who;
        m_tenure = 1;
        m_last   = who;
        m_sel    = (who == 2);
    endtask

    task automatic model_step();
        bit my_done, my_req, other_req, expired;
        if (!rst_n) begin
            m_owner = 0; m_tenure = 0; m_last = 2; m_sel = 0; m_to = 0;
            return;
        end
        m_to = 0;
        if (m_owner == 0) begin
            if (req_a && req_b) model_grant(m_last == 2 ? 1 : 2);
            else if (req_a)     model_grant(1);
            else if (req_b)     model_grant(2);
        end else begin
            my_done   = (m_owner == 1) ? done_a : done_b;
            my_req    = (m_owner == 1) ? req_a  : req_b;
            other_req = (m_owner == 1) ? req_b  : req_a;
            expired   = (m_tenure == MAX_HOLD);
            if (my_done || !my_req || expired) begin
                m_to = !my_done && my_req;
                if (other_req) model_grant(3 - m_owner);
                else begin
                    m_owner  = 0;
                    m_tenure = 0;
                end
            end else begin
                m_tenure++;
            end
        end
    endtask

    task automatic compare();
        logic [WIDTH-1:0] exp_z;
        exp_z = (m_owner == 1) ? data_a : (m_owner == 2) ? data_b : '0;
        check_eq("grant_a", grant_a, m_owner == 1);
        check_eq("grant_b", grant_b, m_owner == 2);
        check_eq("sel", sel, m_sel);
        check_eq("data_z", data_z, exp_z);
        check_eq("busy", busy, m_owner != 0);
        check_eq("timeout", timeout, m_to);
        check_eq("one_hot_grant", grant_a & grant_b, 0);
        check_eq("busy_is_or", busy, grant_a | grant_b);
        check_eq("timeout_twice", r_prev_to & timeout, 0);
        r_prev_to = timeout;
    endtask

    task automatic step(input logic rn, input logic ra, input logic rb,
                        input logic da, input logic db);
        rst_n  = rn;
        req_a  = ra;
        req_b  = rb;
        done_a = da;
        done_b = db;
        data_a = WIDTH'($urandom);
        data_b = WIDTH'($urandom);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    int cnt_gb, cnt_to;

    initial begin
        n_checks = 0; n_errors = 0; r_prev_to = 0;
        m_owner = 0; m_tenure = 0; m_last = 2; m_sel = 0; m_to = 0;
        rst_n = 0; req_a = 0; req_b = 0; done_a = 0; done_b = 0;
        data_a = '0; data_b = '0;

        // Reset state, then single A transaction.
        do_reset();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_sel", sel, 0);
        step(1, 1, 0, 0, 0);
        check_eq("a_grant_latency", grant_a, 1);
        check_eq("a_data", data_z, data_a);
        step(1, 1, 0, 1, 0);
        check_eq("a_done_idle", data_z, 0);

        // Both requesting, done pulsed every third cycle: alternation, no gap.
        do_reset();
        step(1, 1, 1, 0, 0);
        check_eq("contend_first_a", grant_a, 1);
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 1, (i % 3) == 2, (i % 3) == 2);
            check_eq("no_bubble", busy, 1);
        end

        // B held with no done: exactly MAX_HOLD grant cycles and one timeout.
        do_reset();
        cnt_gb = 0; cnt_to = 0;
        for (int i = 0; i < MAX_HOLD + 1; i++) begin
            step(1, 0, 1, 0, 0);
            cnt_gb += int'(grant_b);
            cnt_to += int'(timeout);
        end
        check_eq("hold_cycles", cnt_gb, MAX_HOLD);
        check_eq("timeout_pulses", cnt_to, 1);
        check_eq("idle_gap", busy, 0);
        step(1, 0, 1, 0, 0);
        check_eq("regrant_b", grant_b, 1);

        // done_a coinciding with the hold limit: handover without timeout.
        do_reset();
        for (int i = 0; i < MAX_HOLD; i++) step(1, 1, 1, 0, 0);
        check_eq("pre_switch_a", grant_a, 1);
        step(1, 1, 1, 1, 0);
        check_eq("switch_b", grant_b, 1);
        check_eq("done_no_timeout", timeout, 0);

        // Reset in the middle of a B grant.
        do_reset();
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        check_eq("pre_rst_b", grant_b, 1);
        step(0, 1, 1, 0, 0);
        check_eq("mid_rst_gb", grant_b, 0);
        check_eq("mid_rst_sel", sel, 0);
        check_eq("mid_rst_to", timeout, 0);
        step(1, 1, 1, 0, 0);
        check_eq("post_rst_a_first", grant_a, 1);

        // Random traffic: requests mostly high, done rare, occasional reset.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_arbiter_2to1.md
MUX_ARBITER_2TO1 -- requirements
Module: mux_arbiter_2to1

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: data bus width per requester.
REQ-002 SHALL provide parameter MAX_HOLD, default 16: maximum grant tenure in cycles (legal range 2..255).
REQ-003 SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_a  input  1  requester A wants the shared path.
REQ-006 SHALL have port req_b  input  1  requester B wants the shared path.
REQ-007 SHALL have port done_a  input  1  requester A releases its grant (sampled only while A is granted).
REQ-008 SHALL have port done_b  input  1  requester B releases its grant (sampled only while B is granted).
REQ-009 SHALL have port data_a  input  WIDTH  requester A data.
REQ-010 SHALL have port data_b  input  WIDTH  requester B data.
REQ-011 SHALL have port grant_a  output  1  A owns the path (registered).
REQ-012 SHALL have port grant_b  output  1  B owns the path (registered).
REQ-013 SHALL have port sel  output  1  mux select, 0 = A, 1 = B (registered).
REQ-014 SHALL have port data_z  output  WIDTH  muxed data.
REQ-015 SHALL have port busy  output  1  high when either grant is high.
REQ-016 SHALL have port timeout  output  1  one-cycle pulse on forced release.

Function
REQ-017 SHALL implement FSM states IDLE, GNT_A, GNT_B; grant_a = (state==GNT_A), grant_b = (state==GNT_B); never both high.
REQ-018 SHALL keep a last_served bit; on contention (req_a & req_b in the decision cycle) the requester not last served wins.
REQ-019 IDLE: req_a only -> GNT_A; req_b only -> GNT_B; both -> per REQ-018; neither -> stay IDLE.
REQ-020 Grant latency SHALL be exactly one cycle: request sampled high at edge N gives grant high after edge N.
REQ-021 SHALL set sel = 0 on entry to GNT_A and sel = 1 on entry to GNT_B; sel SHALL hold its last value in IDLE.
REQ-022 data_z SHALL equal data_a in GNT_A, data_b in GNT_B, all-zero in IDLE (combinational from state and data).
REQ-023 SHALL maintain hold counter: cleared to 0 on every grant entry, incremented each cycle the grant is held.
REQ-024 Release conditions in GNT_x: done_x high, req_x low, or counter == MAX_HOLD-1 (forced).
REQ-025 On release, if the other requester is requesting SHALL go directly to its grant state (no idle bubble); otherwise SHALL go to IDLE.
REQ-026 On forced release only (done_x low, req_x high), timeout SHALL pulse high for exactly the cycle after the release edge; done takes precedence over forced release in the same cycle.
REQ-027 last_served SHALL update on grant entry to the granted requester.
REQ-028 Released requester still holding req SHALL be re-granted from IDLE only if the other requester is idle, i.e. no starvation of the other side.
REQ-029 done_x while the other side is granted SHALL be ignored.

Reset
REQ-030 While rst_n low at a clock edge: state = IDLE, grant_a = grant_b = 0, sel = 0, busy = 0, timeout = 0, counter = 0, last_served = B (A wins first contention).
REQ-031 Reset asserted mid-grant SHALL drop the grant on the next edge with no timeout pulse; reset SHALL have priority over all other inputs.
REQ-032 After rst_n rises, first grant SHALL follow REQ-020 from the first sampled request.

Verification
REQ-033 Reset then req_a=1 one cycle -> grant_a=1, sel=0, data_z=data_a one cycle later; done_a=1 -> IDLE, data_z=0.
REQ-034 Out of reset, req_a=req_b=1 held, done pulsed each 3 cycles -> grants alternate A,B,A,B with no IDLE cycle between.
REQ-035 req_b=1 held, done_b=0, MAX_HOLD=16 -> grant_b high exactly 16 cycles, timeout pulse once, re-grant B after one IDLE cycle.
REQ-036 GNT_A with req_b=1 and done_a=1 at counter==MAX_HOLD-1 -> switch to GNT_B, timeout stays 0.
REQ-037 rst_n low during GNT_B -> grant_b=0, sel=0, timeout=0 next edge; afterwards simultaneous requests grant A first.
REQ-038 Assertion checks all runs: grant_a & grant_b never both 1; busy == grant_a | grant_b; timeout never high two consecutive cycles.
